// File: rtl/or1k_fifo_pkg.sv
// Shared types and helpers for the or1k FIFO controller and its RAM.
package or1k_fifo_pkg;

   // Default RAM address width used when no override is given.
   localparam int FIFO_DEFAULT_ADDR_WIDTH = 4;

   // Level counter for the default-sized FIFO. It is one bit wider than the
   // address so that the value DEPTH can be represented.
   typedef logic [FIFO_DEFAULT_ADDR_WIDTH:0] fifo_level_t;

   // Ceiling log2, for sizing address fields from a depth.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v = value - 1;
      while (v > 0) begin
         result = result + 1;
         v = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/or1k_simple_dpram_sclk.sv
// Single-clock simple dual-port RAM with a registered read port.
module or1k_simple_dpram_sclk
   import or1k_fifo_pkg::*;
#(
   parameter int ADDR_WIDTH    = 4,
   parameter int DATA_WIDTH    = 32,
   parameter int CLEAR_ON_INIT = 0,
   parameter int ENABLE_BYPASS = 1
) (
   input  logic                  clk,
   input  logic [ADDR_WIDTH-1:0] raddr,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic                  we,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Contents are not cleared by hardware; power-up values are undefined
   // and the controller never reads a slot before it has been written.
   if (CLEAR_ON_INIT != 0) begin : g_clear_not_cleared
   end

   // Write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= din;
      end
   end

   if (ENABLE_BYPASS != 0) begin : g_bypass
      // Registered read; a same-address write is forwarded to the output.
      always_ff @(posedge clk) begin
         if (re) begin
            rdata_q <= (we && (raddr == waddr)) ? din : mem[raddr];
         end
      end
   end else begin : g_no_bypass
      // Registered read straight from the array (old data on collision).
      always_ff @(posedge clk) begin
         if (re) begin
            rdata_q <= mem[raddr];
         end
      end
   end

   assign dout = rdata_q;

endmodule

// File: rtl/or1k_dpram_fifo.sv
// First-word-fall-through FIFO around a simple dual-port RAM; the RAM's
// registered read port doubles as the output data register.
module or1k_dpram_fifo
   import or1k_fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  full,
   output logic                  empty
);

   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH+1)'(1);

   logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
   logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
   logic [ADDR_WIDTH:0]   level_q, level_d;
   logic                  out_valid_q, out_valid_d;

   logic push;
   logic pop;
   logic re;

   // Handshakes and flags, all derived from registered state.
   always_comb begin
      full     = (level_q == DEPTH_L);
      in_ready = !full;
      push     = in_valid && in_ready;
      pop      = out_valid_q && out_ready;
      // Refill the output register whenever it is empty or being drained.
      re       = (level_q != '0) && (!out_valid_q || out_ready);
      empty    = (level_q == '0) && !out_valid_q;
   end

   // Next-state for pointers, level and output-register valid.
   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      level_d     = level_q;
      out_valid_d = out_valid_q;
      if (push) begin
         wptr_d = wptr_q + 1'b1;
      end
      if (re) begin
         rptr_d = rptr_q + 1'b1;
      end
      if (push && !re) begin
         level_d = level_q + ONE_L;
      end else if (!push && re) begin
         level_d = level_q - ONE_L;
      end
      if (re) begin
         out_valid_d = 1'b1;
      end else if (pop) begin
         out_valid_d = 1'b0;
      end
   end

   // State register; flush behaves like reset and overrides push/pop.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         level_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         level_q     <= level_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Reads only target slots written at an earlier edge, so no bypass.
   or1k_simple_dpram_sclk #(
      .ADDR_WIDTH    (ADDR_WIDTH),
      .DATA_WIDTH    (DATA_WIDTH),
      .CLEAR_ON_INIT (0),
      .ENABLE_BYPASS (0)
   ) u_mem (
      .clk   (clk),
      .raddr (rptr_q),
      .re    (re),
      .waddr (wptr_q),
      .we    (push),
      .din   (in_data),
      .dout  (out_data)
   );

   assign out_valid = out_valid_q;
   assign level     = level_q;

endmodule

// File: tb/tb_or1k_dpram_fifo.sv
// Scoreboard bench for or1k_dpram_fifo with a 4-entry RAM.
module tb_or1k_dpram_fifo;

   localparam int AW = 2;
   localparam int DW = 32;

   logic          clk;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;
   logic [AW:0]   level;
   logic          full;
   logic          empty;

   int errors;
   int checks;
   logic [DW-1:0] exp_q [$];

   or1k_dpram_fifo #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .level     (level),
      .full      (full),
      .empty     (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      checks = checks + 1;
      if (act !== req) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one word; record it as expected at the cycle it is accepted.
   task automatic push_word(input logic [DW-1:0] d);
      bit done;
      done = 0;
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(d);
            $display("push data=0x%0h", d);
            done = 1;
         end
         step();
      end
      if (!done) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL push_timeout: got stalled expected accepted data=0x%0h", d);
      end
   endtask

   // Monitor: every completed pop is compared against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && !flush && out_valid && out_ready) begin
         checks = checks + 1;
         if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL pop_unexpected: got 0x%0h expected nothing", out_data);
         end else begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            if (out_data !== e) begin
               errors = errors + 1;
               $display("FAIL pop_data: got 0x%0h expected 0x%0h", out_data, e);
            end else begin
               $display("pop data=0x%0h", out_data);
            end
         end
      end
   end

   // Global time limit.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit drained;
      errors    = 0;
      checks    = 0;
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (3) step();
      rst = 1'b0;

      // 1. Reset state.
      @(negedge clk);
      check("rst_in_ready", DW'(in_ready), 1);
      check("rst_out_valid", DW'(out_valid), 0);
      check("rst_level", DW'(level), 0);
      check("rst_empty", DW'(empty), 1);
      check("rst_full", DW'(full), 0);
      step();

      // 2. Single word, two-cycle latency, then pop.
      out_ready = 1'b1;
      push_word(32'hA1);
      in_valid = 1'b0;
      @(negedge clk);
      check("lat_ov_edge0", DW'(out_valid), 0);
      check("lat_level_edge0", DW'(level), 1);
      step();
      @(negedge clk);
      check("lat_ov_edge1", DW'(out_valid), 1);
      check("lat_level_edge1", DW'(level), 0);
      step();
      @(negedge clk);
      check("pop_empty", DW'(empty), 1);
      step();

      // 3. Fill with the consumer stalled; sixth word must wait.
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) push_word(DW'(32'h10 + k));
      @(negedge clk);
      check("fill_level", DW'(level), 4);
      check("fill_full", DW'(full), 1);
      check("fill_in_ready", DW'(in_ready), 0);
      check("fill_out_data", out_data, 32'h10);
      in_valid = 1'b1;
      in_data  = 32'h15;
      step();
      step();
      @(negedge clk);
      check("stall_level", DW'(level), 4);
      check("stall_in_ready", DW'(in_ready), 0);
      step();

      // 4. Drain at full rate; in_ready returns one cycle after the first re.
      out_ready = 1'b1;
      @(negedge clk);
      check("drain_in_ready_pre", DW'(in_ready), 0);
      step();
      @(negedge clk);
      check("drain_in_ready_post", DW'(in_ready), 1);
      exp_q.push_back(32'h15);
      $display("push data=0x15");
      step();
      in_valid = 1'b0;
      drained = 0;
      for (int i = 0; i < 20 && !drained; i++) begin
         @(negedge clk);
         if (empty) drained = 1;
         step();
      end
      check("drain_empty", DW'(drained), 1);
      check("drain_sb_empty", DW'(exp_q.size()), 0);

      // 5. Ten words streamed at one per clock; pointers wrap, no bubbles.
      in_valid = 1'b1;
      in_data  = 0;
      for (int k = 0; k <= 12; k++) begin
         @(negedge clk);
         check($sformatf("wrap_ov_%0d", k), DW'(out_valid), DW'((k >= 2 && k <= 11) ? 1 : 0));
         if (k < 10) begin
            exp_q.push_back(DW'(k));
            $display("push data=0x%0h", k);
         end
         step();
         in_data  = DW'(k + 1);
         in_valid = (k + 1 < 10);
      end
      check("wrap_sb_empty", DW'(exp_q.size()), 0);

      // 6. Flush with data in flight and a simultaneous push.
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) push_word(DW'(32'h30 + k));
      in_valid = 1'b1;
      in_data  = 32'h77;
      flush    = 1'b1;
      @(negedge clk);
      check("pre_flush_level", DW'(level), 3);
      check("pre_flush_ov", DW'(out_valid), 1);
      step();
      exp_q.delete();
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("flush_level", DW'(level), 0);
      check("flush_ov", DW'(out_valid), 0);
      check("flush_empty", DW'(empty), 1);
      out_ready = 1'b1;
      repeat (5) step();
      @(negedge clk);
      check("post_flush_ov", DW'(out_valid), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
